// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared state type, BCD constants and nine's-complement helper
// for the serial BCD adder/subtractor.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      COMP = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [3:0] BCD_NINE = 4'd9;
   localparam logic [3:0] BCD_ADJ  = 4'd6;

   function automatic logic [3:0] nines_c(input logic [3:0] d);
      return BCD_NINE - d;
   endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// rtl/bcd_digit_cell.sv - one BCD digit of add, optionally against the nine's
// complement of b; the decimal-adjusted digit and carry out are combinational.
module bcd_digit_cell
   import bcd_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   input  logic       comp_b,
   output logic [3:0] digit,
   output logic       cout
);

   logic [3:0] b_eff;
   logic [4:0] sum;

   always_comb begin
      b_eff = comp_b ? nines_c(b) : b;
      sum   = {1'b0, a} + {1'b0, b_eff} + {4'b0000, cin};
      if (sum > 5'd9) begin
         digit = sum[3:0] + BCD_ADJ;
         cout  = 1'b1;
      end else begin
         digit = sum[3:0];
         cout  = 1'b0;
      end
   end

endmodule

// File: rtl/bcd_serial_addsub.sv
// rtl/bcd_serial_addsub.sv - signed-magnitude BCD add/subtract, one digit per clock,
// LS digit first; BCD_DIGIT_CHECK_EN adds invalid-digit rejection at accept.
module bcd_serial_addsub
   import bcd_pkg::*;
#(
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  op,
   input  logic                  a_sign,
   input  logic [4*DIGITS-1:0]   a_mag,
   input  logic                  b_sign,
   input  logic [4*DIGITS-1:0]   b_mag,
   output logic                  busy,
   output logic                  done,
   output logic                  res_sign,
   output logic [4*DIGITS-1:0]   res_mag,
   output logic                  overflow,
   output logic                  err
);

   localparam int W  = 4 * DIGITS;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   state_t         state;
   logic [IW-1:0]  idx;
   logic [W-1:0]   a_sr, b_sr, work, work_next;
   logic           carry, eff_sub, a_sign_q;
   logic [3:0]     cell_a, cell_b, cell_digit;
   logic           cell_comp, cell_cout;
   logic           last, zero;

   // COMP reuses the adder: 0 + (9 - d) + carry gives the ten's complement
   assign cell_a    = (state == COMP) ? 4'd0 : a_sr[3:0];
   assign cell_b    = (state == COMP) ? work[3:0] : b_sr[3:0];
   assign cell_comp = (state == COMP) | eff_sub;

   bcd_digit_cell u_cell (
      .a      (cell_a),
      .b      (cell_b),
      .cin    (carry),
      .comp_b (cell_comp),
      .digit  (cell_digit),
      .cout   (cell_cout)
   );

   assign work_next = (work >> 4) | (W'(cell_digit) << (W - 4));
   assign last      = (idx == IW'(DIGITS - 1));
   assign zero      = (work_next == '0);
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);

`ifdef BCD_DIGIT_CHECK_EN
   function automatic logic has_bad_digit(input logic [W-1:0] x);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < DIGITS; i++)
         if (x[4*i +: 4] > BCD_NINE) bad = 1'b1;
      return bad;
   endfunction

   logic bad_in;
   assign bad_in = has_bad_digit(a_mag) | has_bad_digit(b_mag);
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         idx      <= '0;
         a_sr     <= '0;
         b_sr     <= '0;
         work     <= '0;
         carry    <= 1'b0;
         eff_sub  <= 1'b0;
         a_sign_q <= 1'b0;
         res_sign <= 1'b0;
         res_mag  <= '0;
         overflow <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
         err      <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (start) begin
`ifdef BCD_DIGIT_CHECK_EN
               err <= bad_in;
               if (bad_in) begin
                  res_mag  <= '0;
                  res_sign <= 1'b0;
                  overflow <= 1'b0;
                  state    <= DONE;
               end else
`endif
               begin
                  a_sr     <= a_mag;
                  b_sr     <= b_mag;
                  work     <= '0;
                  a_sign_q <= a_sign;
                  eff_sub  <= op ^ a_sign ^ b_sign;
                  carry    <= op ^ a_sign ^ b_sign;
                  idx      <= '0;
                  state    <= ADD;
               end
            end
            ADD: begin
               a_sr  <= a_sr >> 4;
               b_sr  <= b_sr >> 4;
               work  <= work_next;
               carry <= cell_cout;
               idx   <= idx + 1'b1;
               if (last) begin
                  idx <= '0;
                  // a subtract with no final carry means |A| < |B|: result needs re-complementing
                  if (!eff_sub || cell_cout) begin
                     res_mag  <= work_next;
                     overflow <= !eff_sub && cell_cout;
                     res_sign <= zero ? 1'b0 : a_sign_q;
                     state    <= DONE;
                  end else begin
                     carry <= 1'b1;
                     state <= COMP;
                  end
               end
            end
            COMP: begin
               work  <= work_next;
               carry <= cell_cout;
               idx   <= idx + 1'b1;
               if (last) begin
                  idx      <= '0;
                  res_mag  <= work_next;
                  overflow <= 1'b0;
                  res_sign <= zero ? 1'b0 : ~a_sign_q;
                  state    <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// tb/tb_bcd_serial_addsub.sv - directed self-checking bench for bcd_serial_addsub
// (DIGITS=3); expectations follow BCD_DIGIT_CHECK_EN when defined.
module tb_bcd_serial_addsub;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        op = 1'b0;
   logic        a_sign = 1'b0;
   logic [11:0] a_mag = '0;
   logic        b_sign = 1'b0;
   logic [11:0] b_mag = '0;
   logic        busy, done, res_sign, overflow, err;
   logic [11:0] res_mag;

   int errors = 0;
   int checks = 0;

   bcd_serial_addsub #(.DIGITS(3)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op       (op),
      .a_sign   (a_sign),
      .a_mag    (a_mag),
      .b_sign   (b_sign),
      .b_mag    (b_mag),
      .busy     (busy),
      .done     (done),
      .res_sign (res_sign),
      .res_mag  (res_mag),
      .overflow (overflow),
      .err      (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // poke: re-pulse start with different operands while the op is in flight
   task automatic run_op(input string tag, input logic o,
                         input logic as, input logic [11:0] am,
                         input logic bs, input logic [11:0] bm,
                         input logic es, input logic [11:0] em,
                         input logic eo, input logic ee,
                         input int elat, input bit chk_res, input bit poke);
      int lat;
      @(negedge clk);
      start = 1'b1; op = o; a_sign = as; a_mag = am; b_sign = bs; b_mag = bm;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      while (!done && lat < 20) begin
         if (poke && lat == 2) begin
            start = 1'b1; op = 1'b0; a_mag = 12'h999; b_mag = 12'h999;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
      check({tag, ":latency"}, lat, elat);
      check({tag, ":busy_at_done"}, busy, 1'b1);
      check({tag, ":err"}, err, ee);
      if (chk_res) begin
         check({tag, ":mag"}, res_mag, em);
         check({tag, ":sign"}, res_sign, es);
         check({tag, ":ovf"}, overflow, eo);
      end
      @(posedge clk); #1;
      check({tag, ":idle_after"}, {busy, done}, 2'b00);
      if (chk_res) check({tag, ":hold"}, res_mag, em);
   endtask

   initial begin
      int done_seen;
      #1;
      check("rst:busy", busy, 1'b0);
      check("rst:done", done, 1'b0);
      check("rst:outs", {res_sign, overflow, err, res_mag}, 15'h0);
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;

      run_op("add_123_456", 0, 0, 12'h123, 0, 12'h456, 0, 12'h579, 0, 0, 4, 1, 0);
      run_op("sub_500_123", 1, 0, 12'h500, 0, 12'h123, 0, 12'h377, 0, 0, 4, 1, 0);
      run_op("sub_123_500", 1, 0, 12'h123, 0, 12'h500, 1, 12'h377, 0, 0, 7, 1, 0);
      run_op("add_999_001", 0, 0, 12'h999, 0, 12'h001, 0, 12'h000, 1, 0, 4, 1, 0);
      run_op("add_n999_n001", 0, 1, 12'h999, 1, 12'h001, 0, 12'h000, 1, 0, 4, 1, 0);
      run_op("add_n250_250", 0, 1, 12'h250, 0, 12'h250, 0, 12'h000, 0, 0, 4, 1, 0);
      run_op("sub_n120_n045", 1, 1, 12'h120, 1, 12'h045, 1, 12'h075, 0, 0, 4, 1, 0);
      run_op("add_300_n450", 0, 0, 12'h300, 1, 12'h450, 1, 12'h150, 0, 0, 7, 1, 0);
      run_op("start_ignored", 1, 0, 12'h500, 0, 12'h123, 0, 12'h377, 0, 0, 4, 1, 1);

      // abort during the complement pass
      @(negedge clk);
      start = 1'b1; op = 1'b1; a_sign = 0; a_mag = 12'h123; b_sign = 0; b_mag = 12'h500;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("abort:busy_before", busy, 1'b1);
      rst = 1'b1;
      #1;
      check("abort:busy", busy, 1'b0);
      check("abort:done", done, 1'b0);
      check("abort:outs", {res_sign, overflow, err, res_mag}, 15'h0);
      @(negedge clk); rst = 1'b0;
      done_seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (done) done_seen++;
      end
      check("abort:no_done", done_seen, 0);

`ifdef BCD_DIGIT_CHECK_EN
      run_op("bad_digit", 0, 1, 12'h1A3, 0, 12'h001, 0, 12'h000, 0, 1, 1, 1, 0);
`else
      run_op("bad_digit", 0, 1, 12'h1A3, 0, 12'h001, 0, 12'h000, 0, 0, 4, 0, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
